// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with hold/shift/rotate/load modes,
// clock enable, and an autonomous multi-position burst shifter.
module univ_shift_reg #(
  parameter int unsigned N  = 8,
  parameter int unsigned LW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  d,
  input  logic          sin_r,
  input  logic          sin_l,
  input  logic          start,
  input  logic [LW-1:0] burst_len,
  input  logic          burst_dir,
  output logic [N-1:0]  q,
  output logic          sout_r,
  output logic          sout_l,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [LW-1:0] cnt;
  logic          dir;
  logic [LW-1:0] len_clamped;

  // Requested burst lengths beyond the register width saturate at N.
  always_comb begin
    len_clamped = burst_len;
    if (burst_len > LW'(N)) len_clamped = LW'(N);
  end

  assign sout_r = q[0];
  assign sout_l = q[N-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (start) begin
              // A zero-length burst completes immediately without shifting.
              if (len_clamped == '0) begin
                done <= 1'b1;
              end else begin
                cnt   <= len_clamped;
                dir   <= burst_dir;
                busy  <= 1'b1;
                state <= RUN;
              end
            end else begin
              case (mode)
                MODE_SHR:  q <= {sin_r, q[N-1:1]};
                MODE_SHL:  q <= {q[N-2:0], sin_l};
                MODE_ROR:  q <= {q[0], q[N-1:1]};
                MODE_ROL:  q <= {q[N-2:0], q[N-1]};
                MODE_LOAD: q <= d;
                MODE_ASR:  q <= {q[N-1], q[N-1:1]};
                default:   q <= q;
              endcase
            end
          end
          RUN: begin
            q   <= dir ? {q[N-2:0], sin_l} : {sin_r, q[N-1:1]};
            cnt <= cnt - LW'(1);
            if (cnt == LW'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register. Successor to the team's fixed-direction 4-bit load/shift-right register.
- Adds:
  - selectable modes: hold, logical shift left/right, rotate left/right, arithmetic shift right, parallel load;
  - clock enable;
  - an autonomous burst engine that shifts a programmed number of positions with a busy/done handshake.
- Used as the datapath core for serializers, LFSR seeding and bit-field alignment in the lab designs.

Parameters:
- N, 8, register width in bits; legal range 2..64.
- LW, $clog2(N+1), width of burst_len; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  clock enable; 0 freezes all state, including the burst engine.
- mode  in  3  operation select; sampled only when busy=0.
- d  in  N  parallel load data.
- sin_r  in  1  serial in for right shifts; enters at bit N-1.
- sin_l  in  1  serial in for left shifts; enters at bit 0.
- start  in  1  burst request pulse.
- burst_len  in  LW  number of positions to shift in a burst; range 0..N.
- burst_dir  in  1  burst direction: 0 = logical right, 1 = logical left.
- q  out  N  register contents.
- sout_r  out  1  q[0]; combinational from the register.
- sout_l  out  1  q[N-1]; combinational from the register.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:

Reset:
- reset_n=0 at a rising edge sets q=0, busy=0, done=0 and clears the burst counter.
- Reset wins over en, start and mode, including in the middle of a burst. No partial completion and no done pulse.

Enable:
- en=0: q, busy and the counter hold their values; done is driven 0.
- A start presented while en=0 is ignored.

Mode encoding (applies when busy=0, en=1, start=0):
- 000 hold.
- 001 shift right: q <= {sin_r, q[N-1:1]}.
- 010 shift left: q <= {q[N-2:0], sin_l}.
- 011 rotate right: q <= {q[0], q[N-1:1]}.
- 100 rotate left: q <= {q[N-2:0], q[N-1]}.
- 101 parallel load: q <= d.
- 110 arithmetic shift right: q <= {q[N-1], q[N-1:1]}.
- 111 reserved; behaves as hold.

Burst engine, two states IDLE and RUN:
- IDLE, en=1, start=1, burst_len>0:
  - Capture burst_len into the counter and burst_dir internally.
  - Go to RUN with busy=1 from the next cycle.
  - No shift happens on the start edge.
  - start has priority over mode on that cycle; mode is ignored.
- IDLE, start=1, burst_len=0: no shift, busy stays 0, done=1 on the next cycle.
- IDLE, burst_len>N: clamp to N.
- RUN, en=1, each edge:
  - Perform one logical shift in the captured direction. Right uses sin_r; left uses sin_l.
  - Decrement the counter.
  - When the counter reaches 0: return to IDLE, busy=0, and done=1 for exactly one cycle after the final shift edge.
- RUN: mode, d and start are ignored. A start while busy is dropped, not queued.
- Latency: a burst of length L occupies L cycles of busy (counting enabled cycles only). done asserts in the cycle after the last shift.
- A new start is accepted in the same cycle that done=1.

Timing:
- All outputs are registered except sout_r and sout_l, which are direct taps of q.

Test Plan (N=8):
1. Reset and load: reset_n=0 for 2 cycles -> q=0x00, busy=0, done=0. Then mode=101, d=0xA5 -> q=0xA5 after 1 edge.
2. Modes from q=0x81:
   - rotate right -> 0xC0;
   - rotate left from 0x81 -> 0x03;
   - arithmetic shift right from 0x81 -> 0xC0;
   - shift right with sin_r=0 from 0x81 -> 0x40;
   - shift left with sin_l=1 from 0x81 -> 0x03.
3. Burst: q=0xF0, start with burst_len=4, burst_dir=0, sin_r=0:
   - busy=1 for exactly 4 cycles;
   - q=0x0F when done=1, done high for 1 cycle;
   - mode=101 toggled during busy has no effect.
4. Enable freeze: burst_len=3 left from q=0x01 with sin_l=0; drop en for 2 cycles mid-burst -> q and busy hold, then resume. Final q=0x08, total busy cycles=3 enabled plus 2 frozen.
5. Boundaries:
   - burst_len=0 -> busy stays 0, done pulses once next cycle, q unchanged;
   - burst_len=8 on 0xFF right with sin_r=0 -> q=0x00;
   - start while busy -> ignored.
6. Reset mid-burst: assert reset_n=0 on the 2nd busy cycle -> next edge q=0, busy=0, no done pulse; a following start works normally.
